// File: rtl/riscv_m_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 decode values, FSM state encoding and default datapath width.
package riscv_m_pkg;
  localparam int XLEN_DEF = 32;
  localparam int CNT_W    = 6;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/mdu_sign_prep.sv
// Operand magnitude and result-sign extraction for the multiply/divide unit.
// Purely combinational; signedness of each operand follows funct3.
module mdu_sign_prep
  import riscv_m_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_a_mag,
  output logic [XLEN-1:0] o_b_mag,
  output logic            o_neg_res,
  output logic            o_neg_rem
);
  logic w_a_signed, w_b_signed, w_a_neg, w_b_neg;

  assign w_a_signed = (i_funct3 == F3_MUL) || (i_funct3 == F3_MULH) ||
                      (i_funct3 == F3_MULHSU) || (i_funct3 == F3_DIV) ||
                      (i_funct3 == F3_REM);
  assign w_b_signed = (i_funct3 == F3_MUL) || (i_funct3 == F3_MULH) ||
                      (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);

  assign w_a_neg = w_a_signed && i_a[XLEN-1];
  assign w_b_neg = w_b_signed && i_b[XLEN-1];

  // -(-2^(XLEN-1)) wraps to itself, which is the correct unsigned magnitude
  assign o_a_mag   = w_a_neg ? -i_a : i_a;
  assign o_b_mag   = w_b_neg ? -i_b : i_b;
  assign o_neg_res = w_a_neg ^ w_b_neg;
  assign o_neg_rem = w_a_neg;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide stage: shift-add multiply and restoring
// divide share one 2*XLEN accumulator; fixed latency for every operation.
module muldiv_unit
  import riscv_m_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  input  logic [4:0]      i_rd_in,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd_out,
  output logic            o_rd_wd_en
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);

  state_t              r_state, w_next;
  logic [2:0]          r_f3;
  logic [4:0]          r_rd;
  logic [XLEN-1:0]     r_a, r_b, r_bmag, r_result;
  logic [2*XLEN-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_neg_res, r_neg_rem;

  logic [XLEN-1:0]     w_amag, w_bmag;
  logic                w_neg_res, w_neg_rem;
  logic                w_accept, w_is_div;
  logic [XLEN:0]       w_mul_sum, w_trial;
  logic [2*XLEN-1:0]   w_step, w_prod;
  logic [XLEN-1:0]     w_quot, w_rem, w_fin;
  logic                w_b_zero, w_ovf;

  mdu_sign_prep #(.XLEN(XLEN)) u_sign_prep (
    .i_funct3  (r_f3),
    .i_a       (r_a),
    .i_b       (r_b),
    .o_a_mag   (w_amag),
    .o_b_mag   (w_bmag),
    .o_neg_res (w_neg_res),
    .o_neg_rem (w_neg_rem)
  );

  assign w_accept = (r_state == ST_IDLE) && i_start;
  assign w_is_div = r_f3[2];

  // one iteration: multiply adds B into the high half and shifts right,
  // divide shifts the partial remainder left and keeps it if B fits
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_bmag} : '0);
  assign w_trial   = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_bmag};

  always_comb begin
    w_step = {w_mul_sum, r_acc[XLEN-1:1]};
    if (w_is_div) begin
      if (w_trial[XLEN]) w_step = {r_acc[2*XLEN-2:0], 1'b0};
      else               w_step = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end
  end

  assign w_prod   = r_neg_res ? -r_acc : r_acc;
  assign w_quot   = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem    = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_b_zero = (r_b == '0);
  assign w_ovf    = (r_a == {1'b1, {(XLEN-1){1'b0}}}) && (&r_b) &&
                    ((r_f3 == F3_DIV) || (r_f3 == F3_REM));

  always_comb begin
    w_fin = '0;
    unique case (r_f3)
      F3_MUL:                      w_fin = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fin = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU: begin
        if (w_b_zero)   w_fin = {XLEN{1'b1}};
        else if (w_ovf) w_fin = r_a;
        else            w_fin = w_quot;
      end
      default: begin
        if (w_b_zero)   w_fin = r_a;
        else if (w_ovf) w_fin = '0;
        else            w_fin = w_rem;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (i_start) w_next = ST_CALC;
      ST_CALC: if (r_cnt == CNT_LAST) w_next = ST_FIN;
      ST_FIN:  w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  // CALC step 0 registers magnitudes from the latched operands, keeping the
  // sign-prep negators off the register-file read path; steps 1..XLEN iterate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f3      <= '0;
      r_rd      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_bmag    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
    end else begin
      if (w_accept) begin
        r_f3  <= i_funct3;
        r_rd  <= i_rd_in;
        r_a   <= i_rs1_val;
        r_b   <= i_rs2_val;
        r_cnt <= '0;
      end else if (r_state == ST_CALC) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == '0) begin
          r_acc     <= {{XLEN{1'b0}}, w_amag};
          r_bmag    <= w_bmag;
          r_neg_res <= w_neg_res;
          r_neg_rem <= w_neg_rem;
        end else begin
          r_acc <= w_step;
        end
      end else if (r_state == ST_FIN) begin
        r_result <= w_fin;
      end
    end
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = (r_state == ST_DONE);
  assign o_result   = r_result;
  assign o_rd_out   = r_rd;
  assign o_rd_wd_en = o_done && (r_rd != 5'd0);
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed RV32M vectors, latency,
// busy-time start filtering, rd=0 write suppression and mid-op reset.
module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] rs1 = '0, rs2 = '0;
  logic [4:0]      rd_in = '0;
  logic            busy, done, rd_wd_en;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  int n_chk = 0;
  int n_bad = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (start),
    .i_funct3   (funct3),
    .i_rs1_val  (rs1),
    .i_rs2_val  (rs2),
    .i_rd_in    (rd_in),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_rd_out   (rd_out),
    .o_rd_wd_en (rd_wd_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // drive one request; optionally pulse a junk start while busy and a start
  // in the done cycle, both of which must be ignored
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp,
                        input bit intf);
    int k;
    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1 = a; rs2 = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'b000; rs1 = 32'hDEADBEEF; rs2 = 32'h0BADF00D; rd_in = 5'd17;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    k = 0;
    while (!done && k < 60) begin
      if (intf && k == 3) begin
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd1; rs2 = 32'd1; rd_in = 5'd9;
      end
      if (intf && k == 5) start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_lat"}, k, LAT);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_rd"}, {27'd0, rd_out}, {27'd0, rd});
    chk({tag, "_wen"}, {31'd0, rd_wd_en}, {31'd0, (rd != 5'd0)});
    if (intf) begin
      start = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_done_start_ign"}, {31'd0, busy}, 32'd0);
      start = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int nd;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_rd", {27'd0, rd_out}, 32'd0);
    chk("rst_wen", {31'd0, rd_wd_en}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("mul",     3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0);
    run_op("mulh",    3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 1'b0);
    run_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 1'b0);
    run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'h00000002, 5'd8,  32'hFFFFFFFF, 1'b0);
    run_op("mul_big", 3'b000, 32'h12345678, 32'h00000010, 5'd9,  32'h23456780, 1'b0);
    run_op("div",     3'b100, 32'hFFFFFFF9, 32'h00000002, 5'd10, 32'hFFFFFFFD, 1'b0);
    run_op("rem",     3'b110, 32'hFFFFFFF9, 32'h00000002, 5'd11, 32'hFFFFFFFF, 1'b0);
    run_op("divu",    3'b101, 32'd100,      32'd7,        5'd12, 32'd14,       1'b0);
    run_op("remu",    3'b111, 32'd100,      32'd7,        5'd13, 32'd2,        1'b0);
    run_op("divu0",   3'b101, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 1'b0);
    run_op("remu0",   3'b111, 32'd5,        32'd0,        5'd15, 32'd5,        1'b0);
    run_op("div0",    3'b100, 32'hFFFFFFFB, 32'd0,        5'd16, 32'hFFFFFFFF, 1'b0);
    run_op("rem0",    3'b110, 32'hFFFFFFFB, 32'd0,        5'd18, 32'hFFFFFFFB, 1'b0);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 1'b0);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h00000000, 1'b0);
    run_op("ign",     3'b101, 32'd100,      32'd7,        5'd3,  32'd14,       1'b1);
    run_op("rd0",     3'b000, 32'd3,        32'd4,        5'd0,  32'd12,       1'b0);

    // reset in the middle of a calculation
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; rs1 = 32'd1000; rs2 = 32'd3; rd_in = 5'd21;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_res", result, 32'd0);
    chk("mrst_rd", {27'd0, rd_out}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("mrst_nodone", nd, 0);
    run_op("post_rst", 3'b101, 32'd1000, 32'd3, 5'd21, 32'd333, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
